// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
//   mem_state_type    : MEM stage controller states (IDLE/REQ/WAIT).
//   mem_size_type     : funct3 encodings for loads and stores.
//   MEM_TIMEOUT_WIDTH : width of the optional WAIT-state watchdog counter.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_type;

  typedef logic [2:0] mem_size_type;

  // Loads and stores share encodings, so these are plain constants, not an enum.
  localparam mem_size_type MEM_LB  = 3'b000;
  localparam mem_size_type MEM_LH  = 3'b001;
  localparam mem_size_type MEM_LW  = 3'b010;
  localparam mem_size_type MEM_LBU = 3'b100;
  localparam mem_size_type MEM_LHU = 3'b101;
  localparam mem_size_type MEM_SB  = 3'b000;
  localparam mem_size_type MEM_SH  = 3'b001;
  localparam mem_size_type MEM_SW  = 3'b010;

  localparam int MEM_TIMEOUT_WIDTH = 8;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational load/store lane logic for the MEM stage.
//   funct3     in  access size and signedness
//   addr_lo    in  byte offset within the word
//   is_load    in  access is a load
//   is_store   in  access is a store
//   store_data in  raw store operand
//   load_data  in  raw load word from memory
//   be         out byte enables for a store
//   wdata      out lane-replicated store data
//   fault      out illegal funct3, read+write together, or misaligned access
//   load_ext   out selected lane, sign- or zero-extended
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  mem_size_type          funct3,
  input  logic [1:0]            addr_lo,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] load_ext
);

  function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = b;
    return sgn ? DATA_WIDTH'(sb) : DATA_WIDTH'(b);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = h;
    return sgn ? DATA_WIDTH'(sh) : DATA_WIDTH'(h);
  endfunction

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        legal_load;
  logic        legal_store;
  logic        misaligned;

  always_comb begin
    lane_byte = load_data[7:0];
    case (addr_lo)
      2'd1:    lane_byte = load_data[15:8];
      2'd2:    lane_byte = load_data[23:16];
      2'd3:    lane_byte = load_data[31:24];
      default: lane_byte = load_data[7:0];
    endcase
    lane_half = addr_lo[1] ? load_data[31:16] : load_data[15:0];
  end

  always_comb begin
    load_ext = load_data;
    case (funct3)
      MEM_LB:  load_ext = extend_byte(lane_byte, 1'b1);
      MEM_LBU: load_ext = extend_byte(lane_byte, 1'b0);
      MEM_LH:  load_ext = extend_half(lane_half, 1'b1);
      MEM_LHU: load_ext = extend_half(lane_half, 1'b0);
      default: load_ext = load_data;
    endcase
  end

  always_comb begin
    be    = 4'h0;
    wdata = store_data;
    case (funct3)
      MEM_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_SH: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      MEM_SW: begin
        be    = 4'hF;
        wdata = store_data;
      end
      default: begin
        be    = 4'h0;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    legal_load  = (funct3 == MEM_LB) || (funct3 == MEM_LH) || (funct3 == MEM_LW) ||
                  (funct3 == MEM_LBU) || (funct3 == MEM_LHU);
    legal_store = (funct3 == MEM_SB) || (funct3 == MEM_SH) || (funct3 == MEM_SW);
    // funct3[1:0] encodes the size: 00 byte, 01 half, 10 word.
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault = (is_load && is_store) ||
            (is_load && !legal_load) ||
            (is_store && !legal_store) ||
            ((is_load || is_store) && misaligned);
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage between the EX/MEM and MEM/WB registers.
// Non-memory ops pass straight to MEM/WB in one cycle. Loads and stores are
// captured, issued on a valid/ready data-memory port, and the stage stalls
// upstream until the transaction finishes. Misaligned or illegal accesses
// produce a one-cycle mem_fault pulse with a non-writing MEM/WB entry.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, ctrl_mem_read, ctrl_mem_write, ctrl_reg_write, funct3, rd,
//   alu_result, write_data        EX/MEM register fields
//   stall                         freeze EX/MEM and upstream (state != IDLE)
//   dmem_req_valid/ready, dmem_we, dmem_addr, dmem_wdata, dmem_be
//                                 data-memory request channel
//   dmem_rsp_valid, dmem_rdata    data-memory load response
//   wb_valid, wb_reg_write, wb_rd, wb_data
//                                 MEM/WB register outputs
//   mem_fault                     one-cycle fault pulse
//
// Optional build macro MEM_TIMEOUT_EN: adds a WAIT-state watchdog that faults
// the load after TIMEOUT_CYCLES WAIT cycles without a response.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  ctrl_mem_read,
  input  logic                  ctrl_mem_write,
  input  logic                  ctrl_reg_write,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  mem_fault
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("mem_stage: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  mem_state_type state, next_state;

  // Captured access (held for the whole REQ/WAIT transaction).
  logic [DATA_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  mem_size_type          f3_p0;
  logic [4:0]            rd_p0;
  logic                  reg_write_p0;
  logic                  we_p0;
  logic [3:0]            be_p0;

  // lsu_align hookup
  logic                  sel_idle;
  mem_size_type          lsu_f3;
  logic [1:0]            lsu_addr_lo;
  logic [3:0]            lsu_be;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic                  lsu_fault;
  logic [DATA_WIDTH-1:0] lsu_load;
  logic                  is_mem_op;

  // next-state strobes for the MEM/WB register
  logic                  capture;
  logic                  wb_fire;
  logic                  wb_we_nxt;
  logic                  fault_nxt;
  logic [4:0]            wb_rd_nxt;
  logic [DATA_WIDTH-1:0] wb_data_nxt;

`ifdef MEM_TIMEOUT_EN
  localparam logic [MEM_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    MEM_TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [MEM_TIMEOUT_WIDTH-1:0] wait_cnt_p0;
  logic                         timeout;

  // Counts WAIT cycles already spent; cleared whenever not in WAIT, so it
  // starts from zero on every entry into WAIT.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) begin
      wait_cnt_p0 <= '0;
    end else begin
      wait_cnt_p0 <= wait_cnt_p0 + 1'b1;
    end
  end

  // True in the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout = (wait_cnt_p0 == TIMEOUT_LAST);
`endif

  // In IDLE the aligner sees the incoming instruction (fault check, lane
  // setup); afterwards it sees the captured access (load extraction).
  assign sel_idle    = (state == IDLE);
  assign lsu_f3      = sel_idle ? funct3 : f3_p0;
  assign lsu_addr_lo = sel_idle ? alu_result[1:0] : addr_p0[1:0];
  assign is_mem_op   = ctrl_mem_read || ctrl_mem_write;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lsu_align (
    .funct3     (lsu_f3),
    .addr_lo    (lsu_addr_lo),
    .is_load    (ctrl_mem_read),
    .is_store   (ctrl_mem_write),
    .store_data (write_data),
    .load_data  (dmem_rdata),
    .be         (lsu_be),
    .wdata      (lsu_wdata),
    .fault      (lsu_fault),
    .load_ext   (lsu_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    wb_fire     = 1'b0;
    wb_we_nxt   = 1'b0;
    fault_nxt   = 1'b0;
    wb_rd_nxt   = rd_p0;
    wb_data_nxt = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          wb_rd_nxt = rd;
          if (!is_mem_op) begin
            wb_fire     = 1'b1;
            wb_we_nxt   = ctrl_reg_write;
            wb_data_nxt = alu_result;
          end else if (lsu_fault) begin
            wb_fire   = 1'b1;
            fault_nxt = 1'b1;
          end else begin
            capture    = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          if (we_p0) begin
            wb_fire    = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          wb_fire     = 1'b1;
          wb_we_nxt   = reg_write_p0;
          wb_data_nxt = lsu_load;
          next_state  = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          wb_fire    = 1'b1;
          fault_nxt  = 1'b1;
          next_state = IDLE;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // ---- EX/MEM -> capture stage (p0) ----
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0      <= alu_result;
      wdata_p0     <= lsu_wdata;
      f3_p0        <= funct3;
      rd_p0        <= rd;
      reg_write_p0 <= ctrl_reg_write;
      we_p0        <= ctrl_mem_write;
      be_p0        <= lsu_be;
    end
  end

  // Request outputs are gated by REQ so they read zero outside a request.
  assign stall          = (state != IDLE);
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = dmem_req_valid & we_p0;
  assign dmem_addr      = dmem_req_valid ? {addr_p0[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem_wdata     = dmem_req_valid ? wdata_p0 : '0;
  assign dmem_be        = dmem_req_valid ? be_p0 : 4'h0;

  // ---- MEM/WB register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      mem_fault    <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      wb_valid     <= wb_fire;
      wb_reg_write <= wb_fire & wb_we_nxt;
      mem_fault    <= fault_nxt;
      if (wb_fire) begin
        wb_rd   <= wb_rd_nxt;
        wb_data <= wb_data_nxt;
      end
    end
  end

endmodule
